// File: rtl/vram_draw_arbiter_pkg.sv
// Shared screen geometry, pixel widths and FSM encoding for the video-memory write-port arbiter.
// The VGA adapter imports the same constants so the two sides never disagree on the mode.
package vram_draw_arbiter_pkg;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;
    localparam int X_W      = 9;
    localparam int Y_W      = 8;
    localparam int COLOR_W  = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } arb_state_t;

endpackage

// File: rtl/vram_draw_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr, wrapping at NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   idx
);

    localparam logic [PTR_W:0] NR = (PTR_W+1)'(NUM_REQ);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] j;
    logic             found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        sum   = '0;
        j     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + (PTR_W+1)'(k);
            if (sum >= NR)
                sum = sum - NR;
            j = sum[PTR_W-1:0];
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = j;
            end
        end
    end

endmodule

// File: rtl/vram_draw_arbiter.sv
// Single video-memory write port shared by the drawing engines, plus a full-screen clear sweep.
// One pixel accepted per clock; outputs are registered, so every write lands one cycle later.
module vram_draw_arbiter
    import vram_draw_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int X_W      = vram_draw_arbiter_pkg::X_W,
    parameter int Y_W      = vram_draw_arbiter_pkg::Y_W,
    parameter int COLOR_W  = vram_draw_arbiter_pkg::COLOR_W,
    parameter int SCREEN_W = vram_draw_arbiter_pkg::SCREEN_W,
    parameter int SCREEN_H = vram_draw_arbiter_pkg::SCREEN_H
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*X_W-1:0]     req_x,
    input  logic [NUM_REQ*Y_W-1:0]     req_y,
    input  logic [NUM_REQ*COLOR_W-1:0] req_color,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       clear_start,
    input  logic [COLOR_W-1:0]         clear_color,
    output logic [X_W-1:0]             vram_x,
    output logic [Y_W-1:0]             vram_y,
    output logic [COLOR_W-1:0]         vram_color,
    output logic                       vram_we,
    output logic                       busy,
    output logic                       clear_done
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [X_W-1:0]   X_LAST   = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(SCREEN_H - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

    arb_state_t           state, state_nx;
    logic [PTR_W-1:0]     ptr;
    logic [X_W-1:0]       cx;
    logic [Y_W-1:0]       cy;
    logic [COLOR_W-1:0]   clr_color;

    logic [NUM_REQ-1:0]   grant;
    logic [PTR_W-1:0]     gidx;
    logic                 xfer;
    logic                 start_clr;
    logic                 last_px;
    logic [X_W-1:0]       sel_x;
    logic [Y_W-1:0]       sel_y;
    logic [COLOR_W-1:0]   sel_color;
    logic                 in_range;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (gidx)
    );

    assign sel_x     = req_x[gidx*X_W +: X_W];
    assign sel_y     = req_y[gidx*Y_W +: Y_W];
    assign sel_color = req_color[gidx*COLOR_W +: COLOR_W];
    assign in_range  = (sel_x <= X_LAST) && (sel_y <= Y_LAST);
    assign last_px   = (cx == X_LAST) && (cy == Y_LAST);
    assign busy      = (state == ST_CLEAR);

    // A clear request pre-empts arbitration in the cycle it arrives.
    always_comb begin
        state_nx  = state;
        req_ready = '0;
        xfer      = 1'b0;
        start_clr = 1'b0;
        case (state)
            ST_IDLE: begin
                if (resetn) begin
                    if (clear_start) begin
                        start_clr = 1'b1;
                        state_nx  = ST_CLEAR;
                    end else begin
                        req_ready = grant;
                        xfer      = |grant;
                    end
                end
            end
            ST_CLEAR: begin
                if (last_px)
                    state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            cx         <= '0;
            cy         <= '0;
            clr_color  <= '0;
            vram_x     <= '0;
            vram_y     <= '0;
            vram_color <= '0;
            vram_we    <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == ST_CLEAR) begin
                vram_x     <= cx;
                vram_y     <= cy;
                vram_color <= clr_color;
                vram_we    <= 1'b1;
                clear_done <= last_px;
                if (cx == X_LAST) begin
                    cx <= '0;
                    cy <= (cy == Y_LAST) ? '0 : cy + 1'b1;
                end else begin
                    cx <= cx + 1'b1;
                end
            end else begin
                vram_x     <= sel_x;
                vram_y     <= sel_y;
                vram_color <= sel_color;
                vram_we    <= xfer && in_range;
                clear_done <= 1'b0;
                if (start_clr) begin
                    clr_color <= clear_color;
                    cx        <= '0;
                    cy        <= '0;
                end else if (xfer) begin
                    ptr <= (gidx == PTR_LAST) ? '0 : gidx + 1'b1;
                end
            end
        end
    end

endmodule
